bcd_countdown: RTL and testbench

BCD_COUNTDOWN -- requirements
Module: bcd_countdown

---
 rtl/bcd_countdown.sv | 154 +++++++++++++++
 tb/tb_bcd_countdown.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown.sv
// Three-digit BCD countdown timer with load, start, pause and a fixed-rate prescaler.
// One decrement occurs every DIV clock cycles while running; reaching 000 produces a one-cycle Done.
module bcd_countdown #(
    parameter int DIV = 50000000
) (
    input  logic        CLK,
    input  logic        Rst,
    input  logic        Load,
    input  logic [11:0] LoadVal,
    input  logic        Start,
    input  logic        Pause,
    output logic [11:0] count,
    output logic        Tick,
    output logic        Busy,
    output logic        Done,
    output logic        Zero
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_r;
    logic [11:0]     count_r;
    logic [PW-1:0]   presc_r;
    logic            tick_r;
    logic            busy_r;
    logic            done_r;
    logic [11:0]     dec_s;

    // Out-of-range BCD digits saturate to 9 rather than being rejected.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        logic [3:0] r;
        if (d > 4'd9) begin
            r = 4'd9;
        end else begin
            r = d;
        end
        return r;
    endfunction

    function automatic logic [11:0] clamp_bcd(input logic [11:0] v);
        return {clamp_digit(v[11:8]), clamp_digit(v[7:4]), clamp_digit(v[3:0])};
    endfunction

    // Only ever applied to a nonzero value, so the hundreds borrow cannot underflow.
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
        h = v[11:8];
        t = v[7:4];
        u = v[3:0];
        if (u != 4'd0) begin
            u = u - 4'd1;
        end else begin
            u = 4'd9;
            if (t != 4'd0) begin
                t = t - 4'd1;
            end else begin
                t = 4'd9;
                h = h - 4'd1;
            end
        end
        return {h, t, u};
    endfunction

    assign dec_s = bcd_dec(count_r);

    // Countdown state machine with registered status outputs.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            state_r <= ST_IDLE;
            count_r <= 12'h000;
            presc_r <= PRESC_ZERO;
            tick_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (Load) begin
            state_r <= ST_IDLE;
            count_r <= clamp_bcd(LoadVal);
            presc_r <= PRESC_ZERO;
            tick_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (Start && (count_r != 12'h000)) begin
                        state_r <= ST_RUN;
                        presc_r <= PRESC_ZERO;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (Pause) begin
                        // Pause wins even on the terminal prescaler cycle.
                        state_r <= ST_PAUSED;
                        busy_r  <= 1'b1;
                    end else if (presc_r == PRESC_MAX) begin
                        presc_r <= PRESC_ZERO;
                        count_r <= dec_s;
                        tick_r  <= 1'b1;
                        if (dec_s == 12'h000) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        presc_r <= presc_r + PRESC_ONE;
                        busy_r  <= 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (!Pause) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_PAUSED;
                    end
                    busy_r <= 1'b1;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign count = count_r;
    assign Tick  = tick_r;
    assign Busy  = busy_r;
    assign Done  = done_r;
    assign Zero  = (count_r == 12'h000);

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed bench for bcd_countdown with DIV=4; expected values are hand-computed.
module tb_bcd_countdown;

    logic        CLK;
    logic        Rst;
    logic        Load;
    logic [11:0] LoadVal;
    logic        Start;
    logic        Pause;
    logic [11:0] count;
    logic        Tick;
    logic        Busy;
    logic        Done;
    logic        Zero;

    int tests_run;
    int fails;
    int tick_cnt;
    int done_cnt;

    bcd_countdown #(.DIV(4)) dut (
        .CLK(CLK), .Rst(Rst), .Load(Load), .LoadVal(LoadVal),
        .Start(Start), .Pause(Pause), .count(count), .Tick(Tick),
        .Busy(Busy), .Done(Done), .Zero(Zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        Rst = 1'b1; Load = 1'b0; LoadVal = 12'h000; Start = 1'b0; Pause = 1'b0;
        step(); step();
        chk("rst_count", count, 12'h000);
        chk("rst_zero", {11'd0, Zero}, 12'd1);
        chk("rst_busy", {11'd0, Busy}, 12'd0);
        chk("rst_tick", {11'd0, Tick}, 12'd0);
        chk("rst_done", {11'd0, Done}, 12'd0);
        Rst = 1'b0;

        // Basic countdown from 003
        Load = 1'b1; LoadVal = 12'h003; step(); Load = 1'b0;
        chk("load3_count", count, 12'h003);
        chk("load3_zero", {11'd0, Zero}, 12'd0);
        Start = 1'b1; step(); Start = 1'b0;
        chk("start_busy", {11'd0, Busy}, 12'd1);
        chk("start_count", count, 12'h003);
        tick_cnt = 0;
        done_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (Tick) tick_cnt++;
            if (Done) done_cnt++;
            chk("cd_count", count, 12'(3 - i / 4));
            chk("cd_tick", {11'd0, Tick}, (i % 4 == 0) ? 12'd1 : 12'd0);
            chk("cd_busy", {11'd0, Busy}, (i < 12) ? 12'd1 : 12'd0);
        end
        chk("cd_done_at_zero", {11'd0, Done}, 12'd1);
        step();
        if (Done) done_cnt++;
        chk("after_done", {11'd0, Done}, 12'd0);
        chk("after_busy", {11'd0, Busy}, 12'd0);
        chk("after_count", count, 12'h000);
        chk("tick_total", 12'(tick_cnt), 12'd3);
        chk("done_total", 12'(done_cnt), 12'd1);

        // Borrow chains
        Load = 1'b1; LoadVal = 12'h100; step(); Load = 1'b0;
        Start = 1'b1; step(); Start = 1'b0;
        repeat (4) step();
        chk("borrow_100", count, 12'h099);
        chk("borrow_100_tick", {11'd0, Tick}, 12'd1);
        Load = 1'b1; LoadVal = 12'h010; step(); Load = 1'b0;
        chk("reload_010_busy", {11'd0, Busy}, 12'd0);
        Start = 1'b1; step(); Start = 1'b0;
        repeat (4) step();
        chk("borrow_010", count, 12'h009);

        // Pause on the terminal prescaler cycle
        Load = 1'b1; LoadVal = 12'h005; step(); Load = 1'b0;
        Start = 1'b1; step(); Start = 1'b0;
        repeat (3) step();
        Pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pause_hold", count, 12'h005);
            chk("pause_busy", {11'd0, Busy}, 12'd1);
            chk("pause_tick", {11'd0, Tick}, 12'd0);
        end
        Pause = 1'b0;
        step();
        chk("release_count", count, 12'h005);
        step();
        chk("resume_dec", count, 12'h004);
        chk("resume_tick", {11'd0, Tick}, 12'd1);

        // Reset mid-run aborts without Done or Tick
        step(); step();
        Rst = 1'b1; step(); Rst = 1'b0;
        chk("abort_count", count, 12'h000);
        chk("abort_busy", {11'd0, Busy}, 12'd0);
        chk("abort_done", {11'd0, Done}, 12'd0);
        chk("abort_tick", {11'd0, Tick}, 12'd0);
        step();
        chk("abort_done2", {11'd0, Done}, 12'd0);

        // Start with zero count stays idle
        Start = 1'b1;
        step();
        chk("zstart_busy", {11'd0, Busy}, 12'd0);
        chk("zstart_done", {11'd0, Done}, 12'd0);
        step();
        chk("zstart_busy2", {11'd0, Busy}, 12'd0);
        chk("zstart_done2", {11'd0, Done}, 12'd0);
        Start = 1'b0;

        // Invalid digits clamp to 9
        Load = 1'b1; LoadVal = 12'hFAB; step(); Load = 1'b0;
        chk("clamp_fab", count, 12'h999);

        // Load mid-run returns to idle and holds
        Start = 1'b1; step(); Start = 1'b0;
        chk("run999_busy", {11'd0, Busy}, 12'd1);
        step(); step();
        Load = 1'b1; LoadVal = 12'h020; step(); Load = 1'b0;
        chk("midload_count", count, 12'h020);
        chk("midload_busy", {11'd0, Busy}, 12'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("midload_hold", count, 12'h020);
        end
        Start = 1'b1; step(); Start = 1'b0;
        repeat (4) step();
        chk("midload_dec", count, 12'h019);

        // Reset has priority over Load
        Rst = 1'b1; Load = 1'b1; LoadVal = 12'h321; step();
        Rst = 1'b0; Load = 1'b0;
        chk("rst_over_load", count, 12'h000);
        chk("rst_over_load_zero", {11'd0, Zero}, 12'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
